// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
// Turns 3-byte SPI mode-0 frames (cmd, addr, data) into a single register-bus
// write, or into a register-bus read whose data is shifted back out on miso.
// The SPI pins are oversampled in the clk domain. No logic runs on sclk.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   sclk       SPI clock (CPOL=0, CPHA=0), asynchronous to clk
//   cs_n       SPI chip select, active-low
//   mosi       SPI data in, MSB first
//   miso       SPI data out, MSB first, forced to 0 while cs_n is high
//   writeb     register-bus write strobe, one clk wide
//   endereco   register-bus address
//   datain     register-bus write data
//   dataout    register-bus read data (combinational from the register block)
//   busy       high while a frame is being handled
//   frame_err  one-clk pulse on a bad command or an aborted frame
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for cs_n to fall
// CMD    | shifting in command byte (bits 1..8)
// ADDR   | shifting in address byte (bits 9..16)
// DATA   | shifting in data byte (bits 17..24); read data goes out on miso
// DONE   | frame complete, extra bits ignored until cs_n rises
// ERR    | bad command seen, rest of frame ignored until cs_n rises
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       writeb,
  output logic [7:0] endereco,
  output logic [7:0] datain,
  input  logic [7:0] dataout,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE, S_ERR
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic                   r_armed;

  state_t     r_state;
  logic [4:0] r_bit_cnt;
  logic [7:0] r_rx;
  logic [7:0] r_tx;
  logic       r_is_wr;
  logic       r_load_tx;
  logic       r_miso;

  logic       w_sclk;
  logic       w_cs;
  logic       w_mosi;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_fall;
  logic       w_cs_rise;
  logic [7:0] w_rx_next;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_rx_next   = {r_rx[6:0], w_mosi};

  // The raw pin gates miso so the line is quiet as soon as the host deselects.
  assign miso = r_miso & ~cs_n;

  // Synchronizers reset to the idle bus level. r_vld tracks when the last
  // stage holds a real pin sample rather than its reset value; a frame may
  // only start once cs_n has really been seen high (r_armed), so a frame
  // already under way when reset releases is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_vld       <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_vld       <= {r_vld[SYNC_STAGES-2:0], 1'b1};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
      if (r_vld[SYNC_STAGES-1] && w_cs) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_is_wr   <= 1'b0;
      r_load_tx <= 1'b0;
      r_miso    <= 1'b0;
      writeb    <= 1'b0;
      endereco  <= '0;
      datain    <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      writeb    <= 1'b0;
      frame_err <= 1'b0;
      r_load_tx <= 1'b0;
      // Read data is captured one cycle after endereco moves, giving the
      // register block's combinational read a full cycle.
      if (r_load_tx) r_tx <= dataout;

      case (r_state)
        S_IDLE: begin
          if (w_cs_fall && r_armed) begin
            r_state   <= S_CMD;
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_is_wr   <= 1'b0;
            r_miso    <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_CMD, S_ADDR, S_DATA: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            if (r_bit_cnt != 5'd0) frame_err <= 1'b1;
          end else begin
            if (w_sclk_fall && (r_state == S_DATA) && !r_is_wr) begin
              r_miso <= r_tx[7];
              r_tx   <= {r_tx[6:0], 1'b0};
            end
            if (w_sclk_rise) begin
              r_rx      <= w_rx_next;
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if ((r_state == S_CMD) && (r_bit_cnt == 5'd7)) begin
                if (w_rx_next == 8'h80) begin
                  r_is_wr <= 1'b1;
                  r_state <= S_ADDR;
                end else if (w_rx_next == 8'h00) begin
                  r_is_wr <= 1'b0;
                  r_state <= S_ADDR;
                end else begin
                  r_state   <= S_ERR;
                  frame_err <= 1'b1;
                end
              end else if ((r_state == S_ADDR) && (r_bit_cnt == 5'd15)) begin
                endereco  <= w_rx_next;
                r_load_tx <= 1'b1;
                r_state   <= S_DATA;
              end else if ((r_state == S_DATA) && (r_bit_cnt == 5'd23)) begin
                r_state <= S_DONE;
                if (r_is_wr) begin
                  datain <= w_rx_next;
                  writeb <= 1'b1;
                end
              end
            end
          end
        end

        S_DONE, S_ERR: begin
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge
// Drives SPI frames into spi_reg_bridge, hosts a two-register block at
// addresses 120/121 behind it, and compares bus/miso behaviour against a
// frame-level reference model.
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       writeb;
  logic [7:0] endereco;
  logic [7:0] datain;
  logic [7:0] dataout;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .writeb(writeb), .endereco(endereco), .datain(datain),
    .dataout(dataout), .busy(busy), .frame_err(frame_err)
  );

  // register block behind the bridge
  logic [7:0] reg120 = 8'h00;
  logic [7:0] reg121 = 8'h00;
  always @(posedge clk) begin
    if (writeb) begin
      if (endereco == 8'd120) reg120 <= datain;
      else if (endereco == 8'd121) reg121 <= datain;
    end
  end
  always_comb begin
    dataout = 8'h00;
    if (endereco == 8'd120) dataout = reg120;
    else if (endereco == 8'd121) dataout = reg121;
  end

  // bus monitor
  int         wr_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  always @(negedge clk) begin
    if (writeb) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= endereco;
      wr_data <= datain;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  // reference model state
  logic [7:0] mdl_mem [0:255];
  logic [7:0] exp_addr = 8'h00;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] mdl_read(input logic [7:0] a);
    if (a == 8'd120 || a == 8'd121) return mdl_mem[a];
    return 8'h00;
  endfunction

  // one SPI bit: mosi set up, miso sampled just before the rising edge
  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    clks(6);
    m = miso;
    sclk = 1'b1;
    clks(6);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nbits, input int gap,
                           output logic [7:0] rd, output logic busy_seen);
    logic [31:0] v;
    logic        m;
    v  = {b0, b1, b2, 8'($urandom)};
    rd = 8'h00;
    cs_n = 1'b0;
    clks(6);
    busy_seen = busy;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(v[31-i], m);
      if (i >= 16 && i < 24) rd[23-i] = m;
    end
    clks(4);
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(gap);
  endtask

  // run a frame and compare with what the frame rules predict
  task automatic run_check(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nbits);
    int         w0, e0, exp_wr, exp_err;
    logic       valid, is_rd_full, bs;
    logic [7:0] rd, exp_rd;
    w0 = wr_cnt;
    e0 = err_cnt;
    valid = (b0 == 8'h80) || (b0 == 8'h00);
    exp_rd = mdl_read(b1);
    is_rd_full = valid && (b0 == 8'h00) && (nbits >= 24);
    exp_err = 0;
    exp_wr  = 0;
    if (nbits >= 1 && nbits < 8) exp_err = 1;
    else if (nbits >= 8 && !valid) exp_err = 1;
    else if (nbits >= 8 && nbits < 24) exp_err = 1;
    if (valid && nbits >= 16) exp_addr = b1;
    if (valid && b0 == 8'h80 && nbits >= 24) begin
      exp_wr = 1;
      mdl_mem[b1] = b2;
    end
    spi_frame(b0, b1, b2, nbits, 10, rd, bs);
    chk("busy_in_frame", bs, 1'b1);
    chk("writeb_pulses", wr_cnt - w0, exp_wr);
    chk("frame_err_pulses", err_cnt - e0, exp_err);
    chk("endereco", endereco, exp_addr);
    chk("busy_after", busy, 1'b0);
    chk("miso_idle", miso, 1'b0);
    if (exp_wr == 1) begin
      chk("wr_addr", wr_addr, b1);
      chk("wr_data", wr_data, b2);
    end
    if (is_rd_full) chk("read_data", rd, exp_rd);
  endtask

  task automatic reset_midframe();
    int          w0, e0;
    logic [31:0] v;
    logic        m;
    w0 = wr_cnt;
    e0 = err_cnt;
    v  = {8'h80, 8'd120, 8'h11, 8'h00};
    cs_n = 1'b0;
    clks(6);
    for (int i = 0; i < 20; i++) spi_bit(v[31-i], m);
    rst = 1'b0;
    clks(2);
    chk("rst_writeb", writeb, 1'b0);
    chk("rst_endereco", endereco, 8'h00);
    chk("rst_datain", datain, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_miso", miso, 1'b0);
    rst = 1'b1;
    exp_addr = 8'h00;
    clks(2);
    for (int i = 20; i < 24; i++) spi_bit(v[31-i], m);
    clks(4);
    chk("post_rst_busy", busy, 1'b0);
    cs_n = 1'b1;
    mosi = 1'b0;
    clks(10);
    chk("post_rst_writeb", wr_cnt - w0, 0);
    chk("post_rst_err", err_cnt - e0, 0);
    chk("post_rst_endereco", endereco, 8'h00);
  endtask

  initial begin
    logic [7:0] rd, a, d, c;
    logic       bs;
    int         w0, e0, n, sel;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;

    rst = 1'b0;
    clks(3);
    chk("reset_writeb", writeb, 1'b0);
    chk("reset_endereco", endereco, 8'h00);
    chk("reset_datain", datain, 8'h00);
    chk("reset_miso", miso, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    rst = 1'b1;
    clks(8);

    run_check(8'h80, 8'd120, 8'hA5, 24);
    run_check(8'h00, 8'd120, 8'h00, 24);
    run_check(8'h80, 8'd121, 8'h3C, 24);
    run_check(8'h00, 8'd121, 8'hFF, 24);
    run_check(8'h00, 8'd200, 8'h55, 24);
    run_check(8'h81, 8'd120, 8'hFF, 24);
    run_check(8'h80, 8'd121, 8'h77, 12);
    run_check(8'h80, 8'd121, 8'h42, 24);
    run_check(8'h00, 8'd121, 8'h00, 0);

    reset_midframe();
    run_check(8'h80, 8'd121, 8'h5A, 24);
    run_check(8'h00, 8'd121, 8'h00, 24);

    // back-to-back frames with minimum cs_n gap, some with 32 bits
    w0 = wr_cnt;
    e0 = err_cnt;
    for (int k = 0; k < 6; k++) begin
      a = (k % 2 == 1) ? 8'd121 : 8'd120;
      d = 8'($urandom);
      n = (k % 3 == 0) ? 32 : 24;
      mdl_mem[a] = d;
      exp_addr = a;
      spi_frame(8'h80, a, d, n, 4, rd, bs);
    end
    clks(10);
    chk("b2b_writeb_pulses", wr_cnt - w0, 6);
    chk("b2b_frame_err", err_cnt - e0, 0);
    chk("b2b_last_addr", wr_addr, exp_addr);
    run_check(8'h00, 8'd120, 8'h00, 24);
    run_check(8'h00, 8'd121, 8'h00, 32);

    // randomized frames
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 3);
      if (sel == 1) c = 8'h00;
      else if (sel == 2) begin
        c = 8'($urandom);
        if (c == 8'h00 || c == 8'h80) c = 8'h81;
      end else c = 8'h80;
      sel = $urandom_range(0, 2);
      a = (sel == 0) ? 8'd120 : (sel == 1) ? 8'd121 : 8'($urandom);
      d = 8'($urandom);
      sel = $urandom_range(0, 9);
      if (sel <= 6) n = 24;
      else if (sel == 7) n = 32;
      else n = $urandom_range(0, 23);
      run_check(c, a, d, n);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
